// File: rtl/rf_pkg.sv
// Shared register-file geometry and write-back defaults.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int unsigned NUM_WB_REQ = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               found
);

  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
    // hold only masks the grant; the winner is still computed
    if (found && !hold) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file write port from a registered stage.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_WB_REQ,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic                      W_en,
  output logic [ADDR_W-1:0]         Rd,
  output logic [DATA_W-1:0]         Wr_data,
  output logic [NUM_REQ-1:0]        last_grant,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .hold   (hold),
    .grant  (grant),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    req_ready = grant & {NUM_REQ{rst_n}};
    xfer      = |req_ready;
    sel_rd    = req_rd[32'(winner)*ADDR_W +: ADDR_W];
    sel_data  = req_data[32'(winner)*DATA_W +: DATA_W];
    ptr_nxt   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      W_en       <= 1'b0;
      Rd         <= '0;
      Wr_data    <= '0;
      last_grant <= '0;
      wr_count   <= '0;
    end else begin
      W_en <= 1'b0;
      if (xfer) begin
        rr_ptr     <= ptr_nxt;
        last_grant <= grant;
        // x0 writes complete the handshake but never reach the register file
        if (sel_rd != REG_ZERO) begin
          W_en     <= 1'b1;
          Rd       <= sel_rd;
          Wr_data  <= sel_data;
          wr_count <= wr_count + CNT_W'(1);
        end
      end
    end
  end

  logic unused_found;
  assign unused_found = found;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a per-cycle behavioural model and literal spot checks.
module tb_rf_wb_arbiter;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_rd = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             hold = 1'b0;
  logic             W_en;
  logic [AW-1:0]    Rd;
  logic [DW-1:0]    Wr_data;
  logic [NR-1:0]    last_grant;
  logic [CW-1:0]    wr_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  rf_wb_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .W_en       (W_en),
    .Rd         (Rd),
    .Wr_data    (Wr_data),
    .last_grant (last_grant),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port; x0 is never written.
  bit [DW-1:0] rf [32];
  always @(posedge clk) begin
    if (W_en && Rd != 0) rf[Rd] <= Wr_data;
  end

  // Behavioural model
  int            m_ptr;
  logic          m_wen;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_lg;
  int            m_cnt;

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int w;
    logic [NR-1:0] r;
    r = '0;
    w = pick(req_valid, m_ptr);
    if (rst_n && !hold && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_ptr <= 0; m_wen <= 1'b0; m_rd <= '0; m_data <= '0; m_lg <= '0; m_cnt <= 0;
    end else begin
      w = pick(req_valid, m_ptr);
      m_wen <= 1'b0;
      if (w >= 0 && !hold) begin
        m_ptr <= (w + 1) % NR;
        m_lg  <= NR'(1) << w;
        if (req_rd[w*AW +: AW] != 0) begin
          m_wen  <= 1'b1;
          m_rd   <= req_rd[w*AW +: AW];
          m_data <= req_data[w*DW +: DW];
          m_cnt  <= (m_cnt + 1) % (1 << CW);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_ready", 64'(req_ready), 64'(exp_ready()));
      chk("m_wen", 64'(W_en), 64'(m_wen));
      chk("m_rd", 64'(Rd), 64'(m_rd));
      chk("m_data", 64'(Wr_data), 64'(m_data));
      chk("m_last_grant", 64'(last_grant), 64'(m_lg));
      chk("m_wr_count", 64'(wr_count), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    // Reset
    step(); chk_on = 1'b1;
    step();
    chk("rst_wen", 64'(W_en), 0);
    chk("rst_rd", 64'(Rd), 0);
    chk("rst_data", 64'(Wr_data), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_cnt", 64'(wr_count), 0);
    rst_n = 1'b1;

    // Single write from req0
    set_req(0, 5'd1, 32'hA5A5_A5A5); req_valid = 2'b01;
    #1 chk("single_ready", 64'(req_ready), 2'b01);
    step(); req_valid = 2'b00;
    chk("single_wen", 64'(W_en), 1);
    chk("single_rd", 64'(Rd), 1);
    chk("single_data", 64'(Wr_data), 32'hA5A5_A5A5);
    chk("single_cnt", 64'(wr_count), 1);
    step();
    chk("single_rf1", 64'(rf[1]), 32'hA5A5_A5A5);
    chk("single_wen_drop", 64'(W_en), 0);

    // x0 drop from req1 (pointer is now 1)
    set_req(1, 5'd0, 32'hFFFF_FFFF); req_valid = 2'b10;
    #1 chk("x0_ready", 64'(req_ready), 2'b10);
    step(); req_valid = 2'b00;
    chk("x0_wen", 64'(W_en), 0);
    chk("x0_cnt", 64'(wr_count), 1);
    chk("x0_rd_hold", 64'(Rd), 1);
    chk("x0_lg", 64'(last_grant), 2'b10);

    // Contention, pointer back at 0
    set_req(0, 5'd2, 32'h5A5A_5A5A); set_req(1, 5'd3, 32'h0000_1234); req_valid = 2'b11;
    #1 chk("cont_ready0", 64'(req_ready), 2'b01);
    step(); req_valid = 2'b10;
    chk("cont_rd2", 64'(Rd), 2);
    chk("cont_lg0", 64'(last_grant), 2'b01);
    #1 chk("cont_ready1", 64'(req_ready), 2'b10);
    step(); req_valid = 2'b00;
    chk("cont_wen2", 64'(W_en), 1);
    chk("cont_rd3", 64'(Rd), 3);
    chk("cont_data3", 64'(Wr_data), 32'h0000_1234);
    chk("cont_lg1", 64'(last_grant), 2'b10);
    chk("cont_cnt", 64'(wr_count), 3);

    // Hold for three cycles
    set_req(0, 5'd4, 32'h4444_4444); set_req(1, 5'd5, 32'h5555_5555);
    hold = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 64'(req_ready), 0);
      step();
      chk("hold_wen", 64'(W_en), 0);
    end
    hold = 1'b0;
    #1 chk("hold_rel_ready", 64'(req_ready), 2'b01);
    step(); req_valid = 2'b10;
    chk("hold_rd4", 64'(Rd), 4);
    step(); req_valid = 2'b00;
    chk("hold_rd5", 64'(Rd), 5);
    chk("hold_cnt", 64'(wr_count), 5);

    // Async reset while a write to x2 is pending
    set_req(0, 5'd2, 32'hDEAD_BEEF); req_valid = 2'b01;
    step(); req_valid = 2'b11;
    chk("ar_wen_pre", 64'(W_en), 1);
    chk("ar_rd_pre", 64'(Rd), 2);
    #2 rst_n = 1'b0;
    #1 chk("ar_wen", 64'(W_en), 0);
    chk("ar_cnt", 64'(wr_count), 0);
    chk("ar_ready", 64'(req_ready), 0);
    chk("ar_lg", 64'(last_grant), 0);
    step();
    chk("ar_rf2", 64'(rf[2]), 32'h5A5A_5A5A);
    rst_n = 1'b1;

    // Continuous contention: fairness and counter wrap
    set_req(0, 5'd6, 32'h6666_6666); set_req(1, 5'd7, 32'h7777_7777);
    #1 chk("burst_ready", 64'(req_ready), 2'b01);
    for (int i = 0; i < 20; i++) step();
    req_valid = 2'b00;
    chk("burst_cnt_wrap", 64'(wr_count), 4);
    chk("burst_lg", 64'(last_grant), 2'b10);
    step();
    chk("burst_rf6", 64'(rf[6]), 32'h6666_6666);
    chk("burst_rf7", 64'(rf[7]), 32'h7777_7777);
    step();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter for the 32x32 register file's single write port (W_en/Rd/Wr_data). It shares that port between NUM_REQ producers (ALU, load unit, CSR path) using a valid/ready handshake and round-robin priority. It drives the register file write port from a registered output stage. Writes to x0 are accepted and dropped. The block sits between the execute/memory stages and the register file.

Parameters:
NUM_REQ, 2, number of write-back requesters (2..4)
ADDR_W, 5, register index width
DATA_W, 32, register data width
CNT_W, 16, width of committed-write counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester write request
req_rd  in  NUM_REQ*ADDR_W  destination index, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant (combinational); transfer = valid & ready
hold  in  1  suppresses all grants this cycle (pipeline stall)
W_en  out  1  register file write enable (registered)
Rd  out  ADDR_W  register file write index (registered)
Wr_data  out  DATA_W  register file write data (registered)
last_grant  out  NUM_REQ  one-hot of most recent accepted requester (registered)
wr_count  out  CNT_W  committed non-x0 writes, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: W_en=0, Rd=0, Wr_data=0, last_grant=0, wr_count=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first valid requester is the winner w.
  - req_ready[w]=1 only if hold=0. At most one ready bit is high.
  - No valid requester: req_ready=0.
- Accept on a rising edge with transfer on w:
  - rr_ptr <= (w+1) mod NUM_REQ.
  - last_grant <= onehot(w).
  - If req_rd[w] != 0: W_en <= 1, Rd <= req_rd[w], Wr_data <= req_data[w], wr_count <= wr_count+1.
  - If req_rd[w] == 0: W_en <= 0. Rd, Wr_data and wr_count hold.
- No transfer (idle or hold=1):
  - W_en <= 0.
  - rr_ptr, Rd, Wr_data, last_grant and wr_count hold.
- Latency: handshake at edge N gives W_en=1 during cycle N..N+1. The register file commits at edge N+1 and reads show the value after it. Throughput is one write per cycle.
- Requester rule: req_rd and req_data stay stable while valid is high and not yet accepted. The arbiter does not latch ungranted requests.
- Same Rd from two requesters: they are serviced in round-robin order. The later grant overwrites.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1. Worst-case wait is NUM_REQ-1 cycles.
- Reset mid-operation: a pending registered write is discarded. W_en drops immediately (asynchronously), no register file write occurs, and rr_ptr returns to 0.
- wr_count wraps from 2^CNT_W-1 to 0 without a flag.

Decomposition:
- Package rf_pkg holds:
  - REG_ADDR_W=5 and REG_DATA_W=32
  - REG_ZERO=5'd0
  - NUM_WB_REQ default
- Sub-module rr_arbiter (NUM_REQ) takes the request vector, pointer and hold, and returns the one-hot grant plus the encoded winner. It is purely combinational.
- The top level owns rr_ptr, the output stage and the counter.

Test Plan:
1. Reset: rst_n=0 for 2 cycles -> W_en=0, Rd=0, Wr_data=0, req_ready=0, wr_count=0.
2. Single write: req0 valid, rd=1, data=A5A5A5A5 -> req_ready=01 that cycle. Next cycle W_en=1, Rd=1, Wr_data=A5A5A5A5, wr_count=1. Register file Rs1=1 reads A5A5A5A5 after the following edge.
3. Contention: req0 (rd=2, 5A5A5A5A) and req1 (rd=3, 00001234) both valid, rr_ptr=0 -> req0 granted first, then req1. W_en high 2 consecutive cycles with Rd=2 then Rd=3. last_grant=01 then 10.
4. x0 drop: req1 rd=0, data=FFFFFFFF -> req_ready=10, W_en stays 0, wr_count unchanged, register 0 still reads 0, rr_ptr advances.
5. Hold: both valid with hold=1 for 3 cycles -> req_ready=00, W_en=0, rr_ptr unchanged. On release, the grant goes to the requester at the saved rr_ptr.
6. Async reset: drop rst_n mid-cycle while W_en=1 (Rd=2) -> W_en=0 immediately, no write to register 2, rr_ptr=0, wr_count=0.
